// File: rtl/spram_word_ctrl.sv
// Word-wide front end for a pair of SB_SPRAM256KA arrays (lo = bits 15:0, hi = bits 31:16).
// Handles valid/ready requests, byte-to-nibble mask expansion, 1-cycle read return and sleep/wake.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_WAKE  | arrays out of SLEEP, waiting WAKE_CYCLES before accepting
//   S_RUN   | requests accepted while sleep_req is low
//   S_SLEEP | arrays held in SLEEP, sleep_ack high
module spram_word_ctrl #(
  parameter int WAKE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  input  logic        sleep_req,
  output logic        sleep_ack,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_din,
  output logic [3:0]  ram_mask_lo,
  output logic [3:0]  ram_mask_hi,
  output logic        ram_wren,
  output logic        ram_cs,
  output logic        ram_sleep,
  output logic        ram_standby,
  output logic        ram_poweroff,
  input  logic [31:0] ram_dout
);

  localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAKE  = 2'd0,
    S_RUN   = 2'd1,
    S_SLEEP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wake_cnt;
  logic          wake_done;
  logic          rd_pend;
  logic          accept;

  assign wake_done = (wake_cnt == WAKE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_WAKE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter only runs in WAKE; any other state leaves it cleared for the next wake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wake_cnt <= '0;
    end else if (state == S_WAKE && !wake_done) begin
      wake_cnt <= wake_cnt + 1'b1;
    end else begin
      wake_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= accept && !req_we;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_WAKE: begin
        if (wake_done) begin
          state_nxt = sleep_req ? S_SLEEP : S_RUN;
        end
      end
      S_RUN: begin
        // Hold off SLEEP until an outstanding read has returned its data.
        if (sleep_req && !rd_pend) begin
          state_nxt = S_SLEEP;
        end
      end
      S_SLEEP: begin
        if (!sleep_req) begin
          state_nxt = S_WAKE;
        end
      end
      default: state_nxt = S_WAKE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    sleep_ack = 1'b0;
    ram_sleep = 1'b0;
    case (state)
      S_RUN:   req_ready = !sleep_req;
      S_SLEEP: begin
        sleep_ack = 1'b1;
        ram_sleep = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;

  // Each byte enable covers two nibbles of the half-word array holding that byte.
  always_comb begin
    ram_cs      = accept;
    ram_wren    = accept && req_we;
    ram_addr    = req_addr;
    ram_din     = req_wdata;
    ram_mask_lo = 4'b0000;
    ram_mask_hi = 4'b0000;
    if (accept && req_we) begin
      ram_mask_lo = {req_be[1], req_be[1], req_be[0], req_be[0]};
      ram_mask_hi = {req_be[3], req_be[3], req_be[2], req_be[2]};
    end
  end

  assign rsp_valid    = rd_pend;
  assign rsp_rdata    = ram_dout;
  assign ram_standby  = 1'b0;
  assign ram_poweroff = 1'b1;

endmodule
